aibnd_txdrv_oe_seq: RTL
=======================

Name: aibnd_txdrv_oe_seq

Overview:
- Registered output-enable sequencer and data launch stage for the AIB pad tri-state inverting driver.
- Sits directly upstream of the driver. Produces its complementary enable pair (en/enb) and its pre-inverted data input, so the pad carries tx_dat while driven.
- Enforces a programmable settle delay before driving and a minimum hi-Z guard time after release. These delays give break-before-make on bidirectional turnaround.

Parameters:
- ON_DLY, 2, cycles from request sampled to en asserted (0 = next edge).
- OFF_DLY, 3, minimum hi-Z cycles after en deasserts before a new drive may start (0 = none).
- CNT_W, 4, delay counter width; must satisfy max(ON_DLY,OFF_DLY) < 2**CNT_W.

Ports:
- clk  input  1  block clock
- rst  input  1  synchronous reset, active-high
- tx_dat  input  1  data to appear on pad while driving
- tx_oe_req  input  1  level request to drive the pad
- dat_in  output  1  registered ~tx_dat, feeds driver data input
- en  output  1  driver enable, registered
- enb  output  1  registered complement of en
- oe_ack  output  1  high exactly while en=1
- oe_busy  output  1  high in any state other than IDLE

Behaviour:
- One clock; reset is synchronous and active-high. All outputs are registered.
- Reset values: dat_in=1, en=0, enb=1, oe_ack=0, oe_busy=0, state=IDLE, cnt=0.
- Reset asserted mid-operation forces the reset values on the next edge, including en=0 immediately. No guard delay is applied.
- Invariant: enb == ~en on every cycle, and both change on the same edge. No cycle may have en=1 with enb=1, or en=0 with enb=0.
- dat_in <= ~tx_dat on every non-reset edge, independent of state: 1-cycle data latency.
- States are IDLE, WAIT_ON, DRIVE and WAIT_OFF.
- IDLE:
  - tx_oe_req=1 with ON_DLY=0 -> DRIVE, en=1 on the same edge.
  - tx_oe_req=1 with ON_DLY>0 -> WAIT_ON, cnt<=ON_DLY-1.
- WAIT_ON:
  - tx_oe_req=0 -> IDLE (abort; en never asserted; no guard time).
  - cnt==0 -> DRIVE, en<=1.
  - Otherwise cnt<=cnt-1.
  - Result: en rises ON_DLY edges after the edge that first sampled the request.
- DRIVE:
  - tx_oe_req=0 -> en<=0 on that edge.
  - OFF_DLY=0 -> IDLE.
  - OFF_DLY>0 -> WAIT_OFF, cnt<=OFF_DLY-1.
- WAIT_OFF:
  - en=0 throughout.
  - tx_oe_req is ignored until cnt==0.
  - At cnt==0 the next state is IDLE regardless of the request. A still-high request is then taken from IDLE on the following edge.
  - Otherwise cnt<=cnt-1.
  - Guaranteed hi-Z: at least OFF_DLY+1 edges between en falling and en rising again.
- oe_ack = en (separate register, same value). oe_busy = (next state != IDLE), registered.
- Counter never wraps: decrement happens only when cnt>0. Counter value is don't-care in IDLE and DRIVE.
- A one-cycle request pulse in IDLE with ON_DLY>0 enters WAIT_ON and then aborts: no en pulse.

Decomposition:
- Shared package aibnd_txdrv_pkg:
  - state enum (IDLE, WAIT_ON, DRIVE, WAIT_OFF), 2-bit encoding.
  - default ON_DLY/OFF_DLY constants.
- One sub-module is natural: aibnd_dly_cnt.
  - Load/decrement down-counter, CNT_W wide, with a zero flag.
  - Instantiated once and shared by WAIT_ON and WAIT_OFF.

Test Plan:
- Reset: hold rst 3 cycles with tx_oe_req=1 and tx_dat=1 -> en=0, enb=1, dat_in=1, oe_busy=0 throughout. Release rst at edge 0 -> en rises at edge 3 (ON_DLY=2).
- Data path: tx_dat toggles 1,0,1 while driving -> dat_in shows 0,1,0 one cycle later. en/enb unaffected.
- Release and guard: drop tx_oe_req at edge 10 while driving, re-raise at edge 11 -> en=0 at edge 10; IDLE at edge 13; WAIT_ON at edge 14; en=1 at edge 16.
- Abort: in IDLE, pulse tx_oe_req for 1 cycle (ON_DLY=2) -> oe_busy pulses, en stays 0, returns to IDLE.
- Zero delays (ON_DLY=0, OFF_DLY=0): req high at edge 5 -> en=1 at edge 5. Req low at edge 8 -> en=0 and oe_busy=0 at edge 8.
- Assertion throughout every test: enb == ~en and oe_ack == en. Also assert rst during DRIVE -> en=0 on that same edge.

Source files
------------

// File: rtl/aibnd_txdrv_pkg.sv
// Shared types and default timing constants for the AIB pad driver
// output-enable sequencer.
package aibnd_txdrv_pkg;

    // Sequencer states; 2-bit encoding.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ON  = 2'd1,
        DRIVE    = 2'd2,
        WAIT_OFF = 2'd3
    } oe_state_e;

    // Default settle delay before driving, in cycles.
    localparam int DEF_ON_DLY  = 2;
    // Default hi-Z guard time after release, in cycles.
    localparam int DEF_OFF_DLY = 3;
    // Default delay counter width; must hold max(ON_DLY, OFF_DLY).
    localparam int DEF_CNT_W   = 4;

endpackage

// File: rtl/aibnd_txdrv_oe_seq_if.sv
// Signal bundle between the pad-side logic that requests a drive and the
// output-enable sequencer feeding the tri-state inverting driver.
interface aibnd_txdrv_oe_seq_if;

    logic tx_dat;
    logic tx_oe_req;
    logic dat_in;
    logic en;
    logic enb;
    logic oe_ack;
    logic oe_busy;

    // Requester side: drives data and the enable request, observes status.
    modport master (
        output tx_dat,
        output tx_oe_req,
        input  dat_in,
        input  en,
        input  enb,
        input  oe_ack,
        input  oe_busy
    );

    // Sequencer side.
    modport slave (
        input  tx_dat,
        input  tx_oe_req,
        output dat_in,
        output en,
        output enb,
        output oe_ack,
        output oe_busy
    );

endinterface

// File: rtl/aibnd_dly_cnt.sv
// Load/decrement down-counter with a zero flag. Shared between the settle
// delay and the hi-Z guard delay of the output-enable sequencer. It saturates
// at zero instead of wrapping, so a stray decrement can never restart a delay.
module aibnd_dly_cnt #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: a load wins over a decrement; decrement stops at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/aibnd_txdrv_oe_seq.sv
// Registered output-enable sequencer and data launch stage for the AIB pad
// tri-state inverting driver. Produces the complementary en/enb pair with a
// settle delay before driving and a hi-Z guard after release, giving
// break-before-make on bidirectional turnaround. Data is launched inverted
// so the pad carries tx_dat through the inverting driver.
module aibnd_txdrv_oe_seq
    import aibnd_txdrv_pkg::*;
#(
    parameter int ON_DLY  = DEF_ON_DLY,
    parameter int OFF_DLY = DEF_OFF_DLY,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    aibnd_txdrv_oe_seq_if.slave  bus
);

    // Counter load values: a delay of N cycles loads N-1 so the exit decision
    // lands on the Nth edge. Zero delays never load, the value is a dummy.
    localparam logic [CNT_W-1:0] ON_LOAD  = (ON_DLY  > 0) ? CNT_W'(ON_DLY  - 1) : '0;
    localparam logic [CNT_W-1:0] OFF_LOAD = (OFF_DLY > 0) ? CNT_W'(OFF_DLY - 1) : '0;

    oe_state_e        state_q, state_d;
    logic             en_q, en_d;
    logic             enb_q, enb_d;
    logic             oe_ack_q, oe_ack_d;
    logic             oe_busy_q, oe_busy_d;
    logic             dat_in_q, dat_in_d;

    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_dec;
    logic             cnt_zero;

    aibnd_dly_cnt #(
        .CNT_W (CNT_W)
    ) u_dly_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // Next-state, counter control and next output values. Outputs are
    // derived from the next state so they register on the same edge as it.
    always_comb begin
        state_d      = state_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.tx_oe_req) begin
                    if (ON_DLY == 0) begin
                        state_d = DRIVE;
                    end else begin
                        state_d      = WAIT_ON;
                        cnt_load     = 1'b1;
                        cnt_load_val = ON_LOAD;
                    end
                end
            end
            WAIT_ON: begin
                if (!bus.tx_oe_req) begin
                    state_d = IDLE;
                end else if (cnt_zero) begin
                    state_d = DRIVE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            DRIVE: begin
                if (!bus.tx_oe_req) begin
                    if (OFF_DLY == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d      = WAIT_OFF;
                        cnt_load     = 1'b1;
                        cnt_load_val = OFF_LOAD;
                    end
                end
            end
            WAIT_OFF: begin
                if (cnt_zero) begin
                    state_d = IDLE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        en_d      = (state_d == DRIVE);
        enb_d     = ~en_d;
        oe_ack_d  = en_d;
        oe_busy_d = (state_d != IDLE);
        dat_in_d  = ~bus.tx_dat;
    end

    // State and output registers; reset drops the drive immediately.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            en_q      <= 1'b0;
            enb_q     <= 1'b1;
            oe_ack_q  <= 1'b0;
            oe_busy_q <= 1'b0;
            dat_in_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            en_q      <= en_d;
            enb_q     <= enb_d;
            oe_ack_q  <= oe_ack_d;
            oe_busy_q <= oe_busy_d;
            dat_in_q  <= dat_in_d;
        end
    end

    assign bus.dat_in  = dat_in_q;
    assign bus.en      = en_q;
    assign bus.enb     = enb_q;
    assign bus.oe_ack  = oe_ack_q;
    assign bus.oe_busy = oe_busy_q;

endmodule
